cpu_sequencer: RTL

- Multi-cycle control unit that drives the ALU, the other end of the ALU's op/flag/branch interface.
- Fetches 32-bit instructions and issues the 5-bit ALU op with operand selects.
- Holds the status register that feeds the ALU flag inputs and captures the ALU flag outputs.
- Applies branch results to the PC and sequences register-file writeback and data-memory LD/ST handshakes.

---
 rtl/cpu_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control unit that drives an ALU.
//
// It fetches a 32-bit instruction, decodes it, issues the ALU op with its
// operand selects, and then does one of the following: writes a result back
// to the register file, runs a data-memory load/store handshake, or applies a
// branch result to the PC. It also holds the {z,n,c,v,s,h} status register
// that feeds the ALU flag inputs.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   imem_req/addr/ack/rdata instruction fetch handshake (addr = pc)
//   alu_op                  ALU operation, nonzero only in EXEC
//   rf_ra, rf_rb            register-file read addresses (IR[23:21], IR[20:18])
//   lit, lit_sel            zero-extended IR[15:0] and its select (IR[17])
//   alu_out/flags/branch    ALU result, flags and branch-taken
//   status                  registered flags fed back to the ALU
//   rf_we/wa/wd             register-file write strobe, address, data
//   dmem_req/we/addr/wdata/rdata/ack  data memory handshake
//   pc, halted, illegal     program counter, halt state, sticky bad-opcode flag
module cpu_sequencer #(
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [4:0]        alu_op,
    output logic [2:0]        rf_ra,
    output logic [2:0]        rf_rb,
    output logic [31:0]       lit,
    output logic              lit_sel,
    input  logic [31:0]       alu_out,
    input  logic [5:0]        alu_flags,
    input  logic              alu_branch,
    output logic [5:0]        status,
    output logic              rf_we,
    output logic [2:0]        rf_wa,
    output logic [31:0]       rf_wd,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'h00;
    localparam logic [4:0] OP_LD   = 5'h01;
    localparam logic [4:0] OP_ST   = 5'h02;
    localparam logic [4:0] OP_BZ   = 5'h10;
    localparam logic [4:0] OP_BNZ  = 5'h11;
    localparam logic [4:0] OP_BRA  = 5'h12;
    localparam logic [4:0] OP_HALT = 5'h1F;

    state_t            state, state_next;
    logic [31:0]       ir;
    logic [31:0]       result;
    logic              mem_we;
    logic [4:0]        op;
    logic              unused_ir_bit;

    function automatic logic is_arith(input logic [4:0] o);
        return (o >= 5'h03) && (o <= 5'h0A);
    endfunction

    function automatic logic is_branch(input logic [4:0] o);
        return (o == OP_BZ) || (o == OP_BNZ) || (o == OP_BRA);
    endfunction

    function automatic logic is_legal(input logic [4:0] o);
        return (o == OP_NOP) || (o == OP_LD) || (o == OP_ST) || is_arith(o) ||
               is_branch(o) || (o == OP_HALT);
    endfunction

    assign op            = ir[31:27];
    assign unused_ir_bit = ir[16];

    // Operand fields come straight from IR, which only changes on a fetch,
    // so they are stable from DECODE through MEM.
    assign rf_ra      = ir[23:21];
    assign rf_rb      = ir[20:18];
    assign lit        = {16'h0000, ir[15:0]};
    assign lit_sel    = ir[17];
    assign rf_wa      = ir[26:24];
    assign rf_wd      = result;
    assign imem_addr  = pc;
    assign halted     = (state == S_HALT);
    assign dmem_we    = (state == S_MEM) && mem_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        alu_op     = 5'h00;
        rf_we      = 1'b0;
        dmem_req   = 1'b0;
        case (state)
            S_FETCH: begin
                // Gated by rst_n so no fetch is requested while reset is held.
                imem_req = rst_n;
                if (imem_ack) state_next = S_DECODE;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                alu_op = op;
                if (is_arith(op))                      state_next = S_WB;
                else if ((op == OP_LD) || (op == OP_ST)) state_next = S_MEM;
                else if (op == OP_HALT)                state_next = S_HALT;
                else                                   state_next = S_FETCH;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_next = mem_we ? S_FETCH : S_WB;
            end
            S_WB: begin
                rf_we      = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_HALT;
        endcase
    end

    // Architectural control state: PC, IR, status, sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= ADDR_W'(RESET_PC);
            ir      <= 32'h0;
            status  <= 6'h00;
            illegal <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (imem_ack) ir <= imem_rdata;
                S_EXEC: begin
                    mem_we <= (op == OP_ST);
                    if (is_arith(op)) begin
                        status <= alu_flags;
                    end else if (is_branch(op)) begin
                        pc <= alu_branch ? alu_out[ADDR_W-1:0] : pc + 1'b1;
                    end else if ((op != OP_LD) && (op != OP_ST) && (op != OP_HALT)) begin
                        // NOP and undefined opcodes both just advance.
                        pc <= pc + 1'b1;
                        if (!is_legal(op)) illegal <= 1'b1;
                    end
                end
                S_MEM:   if (dmem_ack && mem_we) pc <= pc + 1'b1;
                S_WB:    pc <= pc + 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath holding registers; only meaningful while their strobe is up.
    always_ff @(posedge clk) begin
        if (state == S_EXEC) begin
            if (is_arith(op)) result <= alu_out;
            dmem_addr  <= (op == OP_ST) ? lit[ADDR_W-1:0] : alu_out[ADDR_W-1:0];
            dmem_wdata <= alu_out;
        end else if ((state == S_MEM) && dmem_ack && !mem_we) begin
            result <= dmem_rdata;
        end
    end

endmodule
